fft_input_framer: RTL and testbench
===================================

Name: fft_input_framer

Overview:
Source side of the FFT control interface. Takes a raw valid-qualified I/Q sample stream and turns it into fft_control_t framed transfers for fft_pipelined: data_index 0..NUM_POINTS-1, last on the final sample, a per-frame tag and a per-frame reverse flag. It sits directly upstream of fft_pipelined and never truncates a frame once started.

Parameters:
NUM_POINTS, 32, FFT length; power of two, 8..1024.
INDEX_WIDTH, $clog2(NUM_POINTS), width of data_index.
DATA_WIDTH, 16, width of each of I and Q.
TAG_WIDTH, 8, width of the tag counter; tag wraps modulo 2**TAG_WIDTH.

Ports:
Clk  in  1  clock.
Rst  in  1  reset; asynchronous, active-high.
Enable  in  1  permits new frames to start; sampled only at frame boundaries.
Reverse  in  1  requested FFT direction; latched at frame start.
Input_valid  in  1  sample strobe; no backpressure.
Input_i  in  DATA_WIDTH  signed I sample.
Input_q  in  DATA_WIDTH  signed Q sample.
Output_control  out  fft_control_t  valid/last/reverse/data_index/tag to the FFT.
Output_i  out  DATA_WIDTH  registered I.
Output_q  out  DATA_WIDTH  registered Q.
Status_frame_count  out  32  completed frames (optional feature).
Status_discard_count  out  32  samples dropped while idle (optional feature).

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values:
  - Output_control.valid=0, last=0, reverse=0, data_index=0, tag=0.
  - Output_i/Output_q=0.
  - Internal index=0, tag counter=0, state=S_IDLE.
  - Status counters=0.
- Latency: exactly 1 cycle, Input_valid to Output_control.valid. Non-valid cycles output valid=0, and the other control fields hold their last value.
- State S_IDLE:
  - Input_valid=1 and Enable=1 starts a frame on this sample. It is emitted with data_index=0, reverse=Reverse, tag=tag counter. Go to S_ACTIVE.
  - Input_valid=1 and Enable=0: sample discarded (no output); discard count +1.
- State S_ACTIVE:
  - Each Input_valid sample is emitted with data_index=index, using the latched reverse and tag. Index then increments.
  - Gaps of any length in Input_valid are permitted. Index holds during gaps.
- Frame end, sample with index==NUM_POINTS-1:
  - Emitted with last=1.
  - Index resets to 0; tag counter increments and wraps from 2**TAG_WIDTH-1 to 0; frame count +1.
  - Next state is S_ACTIVE if Enable=1, else S_IDLE.
  - In S_ACTIVE, the next valid sample starts a new frame with freshly latched Reverse/tag, with no idle cycle required.
- Enable or Reverse changes mid-frame: no effect until the frame boundary. The frame always completes at NUM_POINTS samples.
- last is 1 only on data_index NUM_POINTS-1 with valid=1.
- Reset asserted mid-frame: outputs are forced to reset values immediately (async). The partial frame is abandoned, and the tag restarts at 0 after reset.
- Status counters saturate at 2**32-1; they do not wrap.

Optional Feature:
FFT_INPUT_FRAMER_STATUS_EN
- Defined: Status_frame_count and Status_discard_count are implemented as above.
- Undefined: both ports are driven constant 0 and the counter logic is omitted. Framing behaviour is identical.

Decomposition:
- dsp_pkg: fft_control_t (existing), plus the state enum fft_input_framer_state_t {S_IDLE, S_ACTIVE}.
- No sub-module: a single registered process for the FSM, index and tag counters.
- The status counters are inline, under the macro.

Test Plan:
1. NUM_POINTS=8, Enable=1, 24 back-to-back samples. Expect 3 frames: index 0..7, last only on index 7, tags 0,1,2, no gap between frames.
2. Enable=0 for 5 samples, then Enable=1 for 8 samples. Expect the first 5 absent from the output, one frame tag 0, discard count 5, frame count 1.
3. Reverse=0 at frame start, toggled to 1 at index 3. Expect the whole frame reverse=0 and the next frame reverse=1. Drop Enable at index 5: frame completes through index 7, then S_IDLE.
4. Random 0-5 cycle gaps between valid samples. Expect output valid pattern = input pattern delayed 1 cycle, and indices contiguous 0..7.
5. TAG_WIDTH=2, 5 frames. Expect tags 0,1,2,3,0.
6. Rst asserted at index 4 for 3 cycles, then resumed. Expect valid=0 immediately, then a new frame starting at index 0 with tag 0.

Source files
------------

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared FFT control transfer type and framer state encoding.
package dsp_pkg;
    localparam int FFT_INDEX_W = 10;
    localparam int FFT_TAG_W = 8;
    typedef struct packed {
        logic                   valid;
        logic                   last;
        logic                   reverse;
        logic [FFT_INDEX_W-1:0] data_index;
        logic [FFT_TAG_W-1:0]   tag;
    } fft_control_t;
    typedef enum logic {S_IDLE, S_ACTIVE} fft_input_framer_state_t;
endpackage

// File: rtl/fft_input_framer_if.sv
// fft_input_framer_if: raw sample stream in, framed FFT transfers and status out.
interface fft_input_framer_if #(parameter int DATA_WIDTH = 16);
    import dsp_pkg::*;
    logic                         Enable;
    logic                         Reverse;
    logic                         Input_valid;
    logic signed [DATA_WIDTH-1:0] Input_i;
    logic signed [DATA_WIDTH-1:0] Input_q;
    fft_control_t                 Output_control;
    logic signed [DATA_WIDTH-1:0] Output_i;
    logic signed [DATA_WIDTH-1:0] Output_q;
    logic [31:0]                  Status_frame_count;
    logic [31:0]                  Status_discard_count;
    modport master (
        output Enable, Reverse, Input_valid, Input_i, Input_q,
        input  Output_control, Output_i, Output_q, Status_frame_count, Status_discard_count
    );
    modport slave (
        input  Enable, Reverse, Input_valid, Input_i, Input_q,
        output Output_control, Output_i, Output_q, Status_frame_count, Status_discard_count
    );
endinterface

// File: rtl/fft_input_framer.sv
// fft_input_framer: frames a valid-qualified I/Q stream into NUM_POINTS-sample FFT transfers.
// Status counters are built only when FFT_INPUT_FRAMER_STATUS_EN is defined.
module fft_input_framer
    import dsp_pkg::*;
#(
    parameter int NUM_POINTS  = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_POINTS),
    parameter int DATA_WIDTH  = 16,
    parameter int TAG_WIDTH   = 8
) (
    input logic Clk,
    input logic Rst,
    fft_input_framer_if.slave bus
);
    fft_input_framer_state_t r_state;
    logic [INDEX_WIDTH-1:0]  r_index;
    logic [TAG_WIDTH-1:0]    r_tag;
    fft_control_t            r_ctrl;
    logic [DATA_WIDTH-1:0]   r_i;
    logic [DATA_WIDTH-1:0]   r_q;
    logic w_accept, w_start, w_end, w_rev;

    assign w_end    = r_index == INDEX_WIDTH'(NUM_POINTS - 1);
    assign w_start  = r_state == S_IDLE || r_index == '0;
    assign w_accept = bus.Input_valid && (r_state == S_ACTIVE || bus.Enable);
    // Reverse is sampled on a frame's first sample, then held in the output field itself
    assign w_rev    = w_start ? bus.Reverse : r_ctrl.reverse;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_tag   <= '0;
            r_ctrl  <= '0;
            r_i     <= '0;
            r_q     <= '0;
        end else begin
            r_ctrl.valid <= w_accept;
            r_ctrl.last  <= w_accept && w_end;
            if (w_accept) begin
                r_ctrl.data_index <= FFT_INDEX_W'(r_index);
                r_ctrl.reverse    <= w_rev;
                r_ctrl.tag        <= FFT_TAG_W'(r_tag);
                r_i               <= bus.Input_i;
                r_q               <= bus.Input_q;
                r_index           <= w_end ? '0 : r_index + 1'b1;
                r_tag             <= w_end ? r_tag + 1'b1 : r_tag;
                r_state           <= w_end && !bus.Enable ? S_IDLE : S_ACTIVE;
            end
        end
    end

    assign bus.Output_control = r_ctrl;
    assign bus.Output_i       = r_i;
    assign bus.Output_q       = r_q;

`ifdef FFT_INPUT_FRAMER_STATUS_EN
    logic [31:0] r_frames;
    logic [31:0] r_discards;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_frames   <= '0;
            r_discards <= '0;
        end else begin
            if (w_accept && w_end && r_frames != '1)
                r_frames <= r_frames + 1'b1;
            if (bus.Input_valid && r_state == S_IDLE && !bus.Enable && r_discards != '1)
                r_discards <= r_discards + 1'b1;
        end
    end
    assign bus.Status_frame_count   = r_frames;
    assign bus.Status_discard_count = r_discards;
`else
    assign bus.Status_frame_count   = '0;
    assign bus.Status_discard_count = '0;
`endif
endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: directed checks of framing, tags, gaps, enable/reverse latching and async reset.
module tb_fft_input_framer;
    import dsp_pkg::*;
    logic Clk = 1'b0;
    logic Rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_frames, exp_discards;
    int   gaps [8] = '{3, 0, 5, 1, 2, 4, 0, 3};
    int   hr, hi, ht;

    always #5 Clk = ~Clk;

    fft_input_framer_if #(.DATA_WIDTH(16)) bus1 ();
    fft_input_framer_if #(.DATA_WIDTH(16)) bus2 ();
    assign bus2.Enable      = bus1.Enable;
    assign bus2.Reverse     = bus1.Reverse;
    assign bus2.Input_valid = bus1.Input_valid;
    assign bus2.Input_i     = bus1.Input_i;
    assign bus2.Input_q     = bus1.Input_q;

    fft_input_framer #(.NUM_POINTS(8), .DATA_WIDTH(16), .TAG_WIDTH(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus1));
    fft_input_framer #(.NUM_POINTS(8), .DATA_WIDTH(16), .TAG_WIDTH(2)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl(input logic v, input logic l, input logic r, input int idx, input int tg);
        return {11'b0, v, l, r, idx[9:0], tg[7:0]};
    endfunction

    task automatic send(input logic v, input logic en, input logic rv, input int d);
        bus1.Input_valid = v;
        bus1.Enable      = en;
        bus1.Reverse     = rv;
        bus1.Input_i     = d[15:0];
        bus1.Input_q     = ~d[15:0];
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        bus1.Input_valid = 1'b0;
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.Enable = 1'b0;
        bus1.Reverse = 1'b0;
        bus1.Input_i = '0;
        bus1.Input_q = '0;
        do_reset();
        check("rst_ctl", bus1.Output_control, ctl(0, 0, 0, 0, 0));
        check("rst_i", {16'b0, bus1.Output_i}, 0);
        check("rst_q", {16'b0, bus1.Output_q}, 0);
        check("rst_frames", bus1.Status_frame_count, 0);
        check("rst_discards", bus1.Status_discard_count, 0);

        // back-to-back frames
        for (int k = 0; k < 24; k++) begin
            send(1, 1, 0, k);
            check("t1_ctl", bus1.Output_control, ctl(1, k % 8 == 7, 0, k % 8, k / 8));
            check("t1_i", {16'b0, bus1.Output_i}, k);
            check("t1_q", {16'b0, bus1.Output_q}, {16'b0, ~k[15:0]});
        end
        send(0, 1, 0, 0);
        check("t1_gap_hold", bus1.Output_control, ctl(0, 0, 0, 7, 2));

        // samples while disabled are dropped
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(1, 0, 0, k);
            check("t2_drop", bus1.Output_control, ctl(0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 8; k++) begin
            send(1, 1, 0, 50 + k);
            check("t2_ctl", bus1.Output_control, ctl(1, k == 7, 0, k, 0));
            check("t2_i", {16'b0, bus1.Output_i}, 50 + k);
        end
        send(0, 1, 0, 0);
`ifdef FFT_INPUT_FRAMER_STATUS_EN
        exp_frames = 1;
        exp_discards = 5;
`else
        exp_frames = 0;
        exp_discards = 0;
`endif
        check("t2_frames", bus1.Status_frame_count, exp_frames);
        check("t2_discards", bus1.Status_discard_count, exp_discards);

        // Reverse and Enable only take effect at frame boundaries
        for (int k = 0; k < 8; k++) begin
            send(1, 1, k >= 3, k);
            check("t3_frameA", bus1.Output_control, ctl(1, k == 7, 0, k, 1));
        end
        for (int k = 0; k < 8; k++) begin
            send(1, k < 5, 1, k);
            check("t3_frameB", bus1.Output_control, ctl(1, k == 7, 1, k, 2));
        end
        send(1, 0, 1, 0);
        check("t3_idle_drop", bus1.Output_control, ctl(0, 0, 1, 7, 2));

        // gapped input from idle
        hr = 1; hi = 7; ht = 2;
        for (int k = 0; k < 8; k++) begin
            repeat (gaps[k]) begin
                send(0, 1, 0, 0);
                check("t4_gap", bus1.Output_control, ctl(0, 0, hr[0], hi, ht));
            end
            send(1, 1, 0, k);
            check("t4_ctl", bus1.Output_control, ctl(1, k == 7, 0, k, 3));
            hr = 0; hi = k; ht = 3;
        end

        // narrow tag counter wraps
        do_reset();
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) begin
                send(1, 1, 0, k);
                if (k == 0) begin
                    check("t5_tag2", {24'b0, bus2.Output_control.tag}, f % 4);
                    check("t5_tag8", {24'b0, bus1.Output_control.tag}, f);
                end
            end
        end

        // asynchronous reset mid-frame
        for (int k = 0; k < 4; k++) begin
            send(1, 1, 0, k);
            check("t6_pre", bus1.Output_control, ctl(1, 0, 0, k, 5));
        end
        bus1.Input_valid = 1'b1;
        bus1.Input_i = 16'd4;
        #2;
        Rst = 1'b1;
        #1;
        check("t6_async_ctl", bus1.Output_control, ctl(0, 0, 0, 0, 0));
        check("t6_async_i", {16'b0, bus1.Output_i}, 0);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("t6_held_ctl", bus1.Output_control, ctl(0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            send(1, 1, 0, 200 + k);
            check("t6_restart", bus1.Output_control, ctl(1, k == 7, 0, k, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
